// File: rtl/led_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_shift_ctrl
// Description : Serializes words LSB first into an external LED shift-register
//               chain with a divided shift strobe and an end-of-frame latch.
// Revision    : 1.0 - initial release
// ============================================================================
module led_shift_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DIV     = 4,
    parameter int LATCH_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             sdata,
    output logic             sen_n,
    output logic             latch,
    output logic             busy
);

    localparam int c_bit_w = $clog2(WIDTH + 1);
    localparam int c_div_w = $clog2(DIV + 1);

    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV - 1);
    localparam logic [3:0]         c_lat_last = 4'(LATCH_W - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_latch = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_data;
    logic               r_last;
    logic [c_bit_w-1:0] r_bit;
    logic [c_div_w-1:0] r_div;
    logic [3:0]         r_lat;
    logic               w_strobe;

    // The strobe lands on the last cycle of each bit period
    assign w_strobe = (r_state == c_st_shift) && (r_div == c_div_last);

    assign in_ready = (r_state == c_st_idle);
    assign busy     = (r_state != c_st_idle);
    assign sen_n    = ~w_strobe;
    assign latch    = (r_state == c_st_latch);
    assign sdata    = (r_state == c_st_shift) & r_data[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_bit   <= '0;
            r_div   <= '0;
            r_lat   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_last  <= in_last;
                        r_bit   <= '0;
                        r_div   <= '0;
                        r_state <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    if (w_strobe) begin
                        r_div  <= '0;
                        r_data <= r_data >> 1;
                        if (r_bit == c_bit_last) begin
                            r_bit   <= '0;
                            r_state <= r_last ? c_st_latch : c_st_idle;
                        end else begin
                            r_bit <= r_bit + c_bit_w'(1);
                        end
                    end else begin
                        r_div <= r_div + c_div_w'(1);
                    end
                end
                c_st_latch: begin
                    if (r_lat == c_lat_last) begin
                        r_lat   <= '0;
                        r_last  <= 1'b0;
                        r_state <= c_st_idle;
                    end else begin
                        r_lat <= r_lat + 4'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_shift_ctrl
// Description : Directed self-checking bench for led_shift_ctrl (DIV=4 and DIV=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_shift_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid, in_last;
    logic       in_ready, sdata, sen_n, latch, busy;
    logic [7:0] b_data;
    logic       b_valid, b_last;
    logic       b_ready, b_sdata, b_sen_n, b_latch, b_busy;
    logic [7:0] sr, mout;
    int         total = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    led_shift_ctrl #(.WIDTH(8), .DIV(4), .LATCH_W(2)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .sdata(sdata), .sen_n(sen_n),
        .latch(latch), .busy(busy)
    );

    led_shift_ctrl #(.WIDTH(8), .DIV(1), .LATCH_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid),
        .in_last(b_last), .in_ready(b_ready), .sdata(b_sdata), .sen_n(b_sen_n),
        .latch(b_latch), .busy(b_busy)
    );

    // External shift register: first bit shifted ends up in bit 0
    always @(posedge clk) begin
        if (!reset) begin
            sr   <= '0;
            mout <= '0;
        end else begin
            if (!sen_n) sr <= {sdata, sr[7:1]};
            if (latch) mout <= sr;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called in an IDLE cycle; w is accepted at this cycle's edge
    task automatic send(input logic [7:0] w, input logic last, input logic [7:0] nd,
                        input logic nl, input bit hold, input int pulse_at);
        in_data  = w;
        in_last  = last;
        in_valid = 1'b1;
        chk("acc_ready", {7'd0, in_ready}, 8'd1);
        tick;
        in_data  = nd;
        in_last  = nl;
        in_valid = hold;
        for (int k = 1; k <= 32; k++) begin
            if (!hold) in_valid = (k == pulse_at);
            chk($sformatf("sen_n_c%0d", k), {7'd0, sen_n}, (k % 4 == 0) ? 8'd0 : 8'd1);
            chk($sformatf("sdata_c%0d", k), {7'd0, sdata}, {7'd0, w[(k-1)/4]});
            chk($sformatf("ready_c%0d", k), {7'd0, in_ready}, 8'd0);
            chk($sformatf("latch_c%0d", k), {7'd0, latch}, 8'd0);
            tick;
        end
        in_valid = hold;
        if (last) begin
            for (int k = 33; k <= 34; k++) begin
                chk($sformatf("latch_c%0d", k), {7'd0, latch}, 8'd1);
                chk($sformatf("lat_sen_n_c%0d", k), {7'd0, sen_n}, 8'd1);
                chk($sformatf("lat_sdata_c%0d", k), {7'd0, sdata}, 8'd0);
                chk($sformatf("lat_ready_c%0d", k), {7'd0, in_ready}, 8'd0);
                tick;
            end
            chk("model_word", mout, w);
        end
        chk("end_ready", {7'd0, in_ready}, 8'd1);
        chk("end_busy", {7'd0, busy}, 8'd0);
        chk("end_latch", {7'd0, latch}, 8'd0);
    endtask

    initial begin
        logic [7:0] exp1;
        reset    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;
        b_data   = 8'h00;
        b_valid  = 1'b0;
        b_last   = 1'b0;
        tick;
        tick;
        chk("rst_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_sen_n", {7'd0, sen_n}, 8'd1);
        chk("rst_latch", {7'd0, latch}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_sdata", {7'd0, sdata}, 8'd0);
        reset = 1'b1;
        tick;

        // DIV=1: one bit per cycle, strobe on every shift cycle
        exp1    = 8'h81;
        b_data  = 8'h81;
        b_last  = 1'b1;
        b_valid = 1'b1;
        chk("d1_ready", {7'd0, b_ready}, 8'd1);
        tick;
        b_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("d1_sen_n_c%0d", k), {7'd0, b_sen_n}, 8'd0);
            chk($sformatf("d1_sdata_c%0d", k), {7'd0, b_sdata}, {7'd0, exp1[k-1]});
            tick;
        end
        for (int k = 9; k <= 10; k++) begin
            chk($sformatf("d1_latch_c%0d", k), {7'd0, b_latch}, 8'd1);
            chk($sformatf("d1_lat_sen_n_c%0d", k), {7'd0, b_sen_n}, 8'd1);
            tick;
        end
        chk("d1_end_ready", {7'd0, b_ready}, 8'd1);
        chk("d1_end_latch", {7'd0, b_latch}, 8'd0);

        send(8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 0);
        // Back-to-back words with in_valid held; data swapped right after acceptance
        send(8'h0F, 1'b0, 8'hF0, 1'b1, 1'b1, 0);
        send(8'hF0, 1'b1, 8'h00, 1'b0, 1'b0, 0);
        // Stray in_valid while busy must be ignored
        send(8'h5A, 1'b1, 8'hC3, 1'b0, 1'b0, 10);

        // Abort after the third strobe of 0xFF
        in_data  = 8'hFF;
        in_last  = 1'b1;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int k = 1; k <= 12; k++) tick;
        reset    = 1'b0;
        in_valid = 1'b1;
        tick;
        chk("abort_sen_n", {7'd0, sen_n}, 8'd1);
        chk("abort_latch", {7'd0, latch}, 8'd0);
        chk("abort_ready", {7'd0, in_ready}, 8'd1);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_sdata", {7'd0, sdata}, 8'd0);
        tick;
        chk("rst_priority_busy", {7'd0, busy}, 8'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        tick;
        chk("post_rst_busy", {7'd0, busy}, 8'd0);
        chk("post_rst_latch", {7'd0, latch}, 8'd0);
        send(8'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_shift_ctrl.md
LED_SHIFT_CTRL -- requirements
Module: led_shift_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bits per word shifted into the downstream shift register chain.
REQ-002 The block SHALL have parameter DIV, default 4 (legal range 1..255), giving the clk cycles per shifted bit.
REQ-003 The block SHALL have parameter LATCH_W, default 2 (legal range 1..15), giving the latch pulse width in clk cycles.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_data  input  WIDTH  word to serialize.
REQ-007 in_valid  input  1  in_data and in_last are valid.
REQ-008 in_last  input  1  the accepted word is the final word of a frame.
REQ-009 in_ready  output  1  the block accepts a word this cycle.
REQ-010 sdata  output  1  serial data to the shift register data input.
REQ-011 sen_n  output  1  active-low shift enable strobe to the shift register.
REQ-012 latch  output  1  active-high frame latch pulse to the LED drivers.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, SHIFT and LATCH.
REQ-015 In IDLE, in_ready SHALL be 1; in SHIFT and LATCH it SHALL be 0.
REQ-016 A word SHALL be accepted on a clk edge where in_valid=1 and in_ready=1; in_data and in_last are captured into internal registers, and the state goes IDLE->SHIFT.
REQ-017 in_valid without in_ready SHALL have no effect; in_data changes after acceptance SHALL not affect the word in flight.
REQ-018 The captured word SHALL be shifted LSB first: bit 0 first and bit WIDTH-1 last, so that after WIDTH strobes word bit i is in shift-register bit i.
REQ-019 Each bit period SHALL last exactly DIV clk cycles; sdata SHALL hold the current bit for the whole period.
REQ-020 sen_n SHALL be 0 for exactly one cycle, the last cycle of each bit period, and 1 otherwise; the first bit period starts the cycle after acceptance.
REQ-021 With DIV=1, sen_n SHALL be 0 on every SHIFT cycle, and sdata SHALL advance one bit per cycle.
REQ-022 A SHIFT episode SHALL produce exactly WIDTH sen_n strobes, i.e. occupy WIDTH*DIV cycles.
REQ-023 After the final strobe, the state SHALL go to LATCH if the captured in_last=1, and to IDLE otherwise.
REQ-024 In LATCH, latch SHALL be 1 for exactly LATCH_W consecutive cycles, starting the cycle after the final strobe; the state then goes to IDLE.
REQ-025 latch SHALL never be 1 while sen_n=0.
REQ-026 Minimum spacing between acceptances SHALL be WIDTH*DIV+1 cycles for a non-last word, and WIDTH*DIV+LATCH_W+1 cycles for a last word.
REQ-027 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and the divider counter ceil(log2(DIV+1)) bits wide; neither SHALL wrap inside an episode.
REQ-028 sdata in IDLE and LATCH SHALL be 0.

Reset
REQ-029 When reset=0 at a clk edge, the state SHALL be IDLE with in_ready=1, sdata=0, sen_n=1, latch=0, busy=0, and all counters and captured registers cleared.
REQ-030 Reset asserted mid-SHIFT or mid-LATCH SHALL abort immediately: no further strobes, no latch pulse, and the word is discarded.
REQ-031 Reset SHALL take priority over acceptance in the same cycle.

Verification
REQ-032 WIDTH=8, DIV=4: accept 0xA5 with in_last=1 -> strobes at cycles 4,8,...,32 after acceptance with sdata 1,0,1,0,0,1,0,1; latch=1 on cycles 33-34; in_ready=1 from cycle 35.
REQ-033 Two words 0x0F (in_last=0) then 0xF0 (in_last=1), in_valid held high -> second acceptance 33 cycles after the first, 16 strobes total, one latch pulse only after the second word.
REQ-034 DIV=1: accept 0x81 with in_last=1 -> sen_n=0 for 8 consecutive cycles with sdata 1,0,0,0,0,0,0,1; latch high for 2 cycles immediately after.
REQ-035 reset=0 after the 3rd strobe of word 0xFF -> sen_n=1, latch=0 and in_ready=1 from the next edge; a subsequent word shifts all 8 bits.
REQ-036 in_valid pulsed while busy=1 -> not accepted; strobe count and timing unchanged.
REQ-037 A shift_reg model (WIDTH=8) driven by sdata and sen_n -> after each latch its registers equal the last word accepted.
